// File: rtl/z_tft_pkg.sv
// Shared types and constants for the TFT43 scan-out prefetch path.
package z_tft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REQ,
    PUSH,
    DRAIN,
    FDONE
  } state_t;

  localparam int TFT_H_ACTIVE = 480;
  localparam int TFT_V_ACTIVE = 272;
  localparam int SDRAM_ADDR_W = 24;
  localparam int BURST_LEN    = 4;

endpackage

// File: rtl/z_sync_fifo.sv
// Single-clock FIFO with registered read data; a pop on empty or during a
// flush returns zero so the consumer never sees stale words.
module z_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wrEn,
  input  logic [DATA_W-1:0]        wrData,
  input  logic                     rdEn,
  output logic [DATA_W-1:0]        rdData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic              doWr;
  logic              doRd;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign doWr  = wrEn && !full && !flush;
  assign doRd  = rdEn && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWr) wrPtr <= wrPtr + 1'b1;
      if (doRd) rdPtr <= rdPtr + 1'b1;
      count <= count + CNT_W'(doWr) - CNT_W'(doRd);
    end
  end

  always_ff @(posedge clk) begin
    if (doWr) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk) begin
    if (rst) rdData <= '0;
    else     rdData <= doRd ? mem[rdPtr] : '0;
  end

endmodule

// File: rtl/z_tft_line_prefetch.sv
// Frame-buffer prefetcher: walks the frame in 4-word bursts through the SDRAM
// arbiter and hands one RGB565 word per pixel enable to the TFT timing side.
module z_tft_line_prefetch
  import z_tft_pkg::*;
#(
  parameter int                       H_ACTIVE    = TFT_H_ACTIVE,
  parameter int                       V_ACTIVE    = TFT_V_ACTIVE,
  parameter int                       LINE_STRIDE = 512,
  parameter logic [SDRAM_ADDR_W-1:0]  BASE_ADDR   = '0,
  parameter int                       FIFO_DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    iFrame_Start,
  input  logic                    iPix_Req,
  output logic [15:0]             oPix_Data,
  output logic                    oPix_Valid,
  output logic                    oUnderflow,
  output logic                    oRd_Req,
  output logic [SDRAM_ADDR_W-1:0] oRd_Addr,
  input  logic                    iRd_Done,
  input  logic [15:0]             iRd_Data1,
  input  logic [15:0]             iRd_Data2,
  input  logic [15:0]             iRd_Data3,
  input  logic [15:0]             iRd_Data4
);

  localparam int COL_W  = $clog2(H_ACTIVE + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W  = $clog2(BURST_LEN);

  state_t                  state;
  state_t                  stateNext;
  logic [COL_W-1:0]        col;
  logic [LINE_W-1:0]       line;
  logic [IDX_W-1:0]        pushIdx;
  logic [15:0]             stage [BURST_LEN];
  logic [CNT_W-1:0]        fifoCount;
  logic                    fifoFull;
  logic                    fifoEmpty;
  logic                    fifoWr;
  logic                    roomOk;
  logic                    issue;
  logic                    lastWord;
  logic                    lineEnd;
  logic                    frameEnd;
  logic [SDRAM_ADDR_W-1:0] nextAddr;

  assign roomOk   = !fifoFull && (int'(fifoCount) <= FIFO_DEPTH - BURST_LEN);
  assign lineEnd  = (int'(col) + BURST_LEN == H_ACTIVE);
  assign frameEnd = lineEnd && (int'(line) == V_ACTIVE - 1);
  assign lastWord = (pushIdx == IDX_W'(BURST_LEN - 1));
  assign nextAddr = BASE_ADDR
                  + SDRAM_ADDR_W'(line) * SDRAM_ADDR_W'(LINE_STRIDE)
                  + SDRAM_ADDR_W'(col);

  // The arbiter cannot abort a burst, so the request stays up while draining.
  assign oRd_Req = (state == REQ) || (state == DRAIN);
  assign fifoWr  = (state == PUSH) && !iFrame_Start;

  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (iFrame_Start) stateNext = CHECK;
      CHECK: begin
        if (!iFrame_Start && en && roomOk) begin
          stateNext = REQ;
          issue     = 1'b1;
        end
      end
      REQ: begin
        if (iRd_Done)          stateNext = iFrame_Start ? CHECK : PUSH;
        else if (iFrame_Start) stateNext = DRAIN;
      end
      PUSH: begin
        if (iFrame_Start)  stateNext = CHECK;
        else if (lastWord) stateNext = frameEnd ? FDONE : CHECK;
      end
      DRAIN: if (iRd_Done) stateNext = CHECK;
      FDONE: if (iFrame_Start) stateNext = CHECK;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line       <= '0;
      col        <= '0;
      pushIdx    <= '0;
      oRd_Addr   <= '0;
      oPix_Valid <= 1'b0;
      oUnderflow <= 1'b0;
    end else begin
      oPix_Valid <= iPix_Req && !fifoEmpty && !iFrame_Start;
      if (iFrame_Start)               oUnderflow <= 1'b0;
      else if (iPix_Req && fifoEmpty) oUnderflow <= 1'b1;
      if (issue) oRd_Addr <= nextAddr;
      if (iFrame_Start) begin
        line    <= '0;
        col     <= '0;
        pushIdx <= '0;
      end else if (state == PUSH) begin
        pushIdx <= pushIdx + 1'b1;
        if (lastWord) begin
          if (lineEnd) begin
            col  <= '0;
            line <= line + 1'b1;
          end else begin
            col  <= col + COL_W'(BURST_LEN);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == REQ && iRd_Done) begin
      stage[0] <= iRd_Data1;
      stage[1] <= iRd_Data2;
      stage[2] <= iRd_Data3;
      stage[3] <= iRd_Data4;
    end
  end

  z_sync_fifo #(
    .DATA_W (16),
    .DEPTH  (FIFO_DEPTH)
  ) uFifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (iFrame_Start),
    .wrEn   (fifoWr),
    .wrData (stage[pushIdx]),
    .rdEn   (iPix_Req),
    .rdData (oPix_Data),
    .count  (fifoCount),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

endmodule

// File: tb/tb_z_tft_line_prefetch.sv
// Bench for z_tft_line_prefetch: arbiter model, queue-based pixel model, directed
// phases followed by a randomized run.
module tb_z_tft_line_prefetch;

  localparam int H_T    = 32;
  localparam int V_T    = 6;
  localparam int STRIDE = 512;
  localparam int DEPTH  = 16;
  localparam int NBURST = (H_T / 4) * V_T;
  localparam int NPIX   = H_T * V_T;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        iFrame_Start = 1'b0;
  logic        iPix_Req = 1'b0;
  logic [15:0] oPix_Data;
  logic        oPix_Valid;
  logic        oUnderflow;
  logic        oRd_Req;
  logic [23:0] oRd_Addr;
  logic        iRd_Done = 1'b0;
  logic [15:0] iRd_Data1 = '0;
  logic [15:0] iRd_Data2 = '0;
  logic [15:0] iRd_Data3 = '0;
  logic [15:0] iRd_Data4 = '0;

  always #5 clk = ~clk;

  z_tft_line_prefetch #(
    .H_ACTIVE    (H_T),
    .V_ACTIVE    (V_T),
    .LINE_STRIDE (STRIDE),
    .BASE_ADDR   (24'h0),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .iFrame_Start (iFrame_Start),
    .iPix_Req     (iPix_Req),
    .oPix_Data    (oPix_Data),
    .oPix_Valid   (oPix_Valid),
    .oUnderflow   (oUnderflow),
    .oRd_Req      (oRd_Req),
    .oRd_Addr     (oRd_Addr),
    .iRd_Done     (iRd_Done),
    .iRd_Data1    (iRd_Data1),
    .iRd_Data2    (iRd_Data2),
    .iRd_Data3    (iRd_Data3),
    .iRd_Data4    (iRd_Data4)
  );

  int nChk = 0;
  int nFail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-buffer content: each word holds its own pixel index within the frame.
  function automatic logic [15:0] pixOf(input logic [23:0] a);
    return 16'((int'(a) / STRIDE) * H_T + (int'(a) % STRIDE));
  endfunction

  function automatic logic [23:0] burstAddr(input int b);
    return 24'((b / (H_T / 4)) * STRIDE + (b % (H_T / 4)) * 4);
  endfunction

  // Arbiter model: accepts a level request, answers after lat cycles.
  int          lat = 6;
  logic        busy = 1'b0;
  int          cnt = 0;
  logic [23:0] aAddr = '0;

  always @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      iRd_Done <= 1'b0;
    end else begin
      iRd_Done <= 1'b0;
      if (busy) begin
        if (cnt == 0) begin
          iRd_Done  <= 1'b1;
          iRd_Data1 <= pixOf(aAddr);
          iRd_Data2 <= pixOf(aAddr + 24'd1);
          iRd_Data3 <= pixOf(aAddr + 24'd2);
          iRd_Data4 <= pixOf(aAddr + 24'd3);
          busy      <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end else if (oRd_Req && !iRd_Done) begin
        busy  <= 1'b1;
        cnt   <= lat - 1;
        aAddr <= oRd_Addr;
      end
    end
  end

  // Behavioural model: FIFO contents as a queue, burst words waiting to land,
  // and the count of accepted bursts in the current frame.
  logic [15:0] fifoQ[$];
  logic [15:0] pendQ[$];
  logic [23:0] reqLog[$];
  logic [15:0] popLog[$];
  int          burstIdx = 0;
  logic        drop = 1'b0;
  logic        under = 1'b0;
  logic        expValid = 1'b0;
  logic [15:0] expData = '0;

  always @(posedge clk) begin
    logic        cRst, cFs, cPr, cEn, cDone, cReq;
    logic [23:0] cAddr;
    logic [15:0] d [4];
    cRst  = rst;
    cFs   = iFrame_Start;
    cPr   = iPix_Req;
    cEn   = en;
    cDone = iRd_Done;
    cReq  = oRd_Req;
    cAddr = oRd_Addr;
    d[0]  = iRd_Data1;
    d[1]  = iRd_Data2;
    d[2]  = iRd_Data3;
    d[3]  = iRd_Data4;
    expValid = 1'b0;
    expData  = '0;
    if (cRst) begin
      fifoQ.delete();
      pendQ.delete();
      burstIdx = 0;
      drop     = 1'b0;
      under    = 1'b0;
    end else if (cFs) begin
      fifoQ.delete();
      pendQ.delete();
      under    = 1'b0;
      burstIdx = 0;
      drop     = cReq && !cDone;
    end else begin
      if (cPr) begin
        if (fifoQ.size() > 0) begin
          expValid = 1'b1;
          expData  = fifoQ.pop_front();
        end else begin
          under = 1'b1;
        end
      end
      if (pendQ.size() > 0) fifoQ.push_back(pendQ.pop_front());
      if (cDone) begin
        if (drop) drop = 1'b0;
        else begin
          for (int k = 0; k < 4; k++) pendQ.push_back(d[k]);
          burstIdx++;
        end
      end
    end
    #1;
    chk("pix_valid", 32'(oPix_Valid), 32'(expValid));
    chk("pix_data", 32'(oPix_Data), 32'(expData));
    chk("underflow", 32'(oUnderflow), 32'(under));
    chk("fifo_count", 32'(dut.uFifo.count), 32'(fifoQ.size()));
    if (cRst) chk("req_after_rst", 32'(oRd_Req), 0);
    else if (cReq) begin
      if (cDone) chk("req_low_after_done", 32'(oRd_Req), 0);
      else begin
        chk("req_held", 32'(oRd_Req), 1);
        chk("addr_stable", 32'(oRd_Addr), 32'(cAddr));
      end
    end else if (oRd_Req) begin
      reqLog.push_back(oRd_Addr);
      chk("req_addr", 32'(oRd_Addr), 32'(burstAddr(burstIdx)));
      chk("req_in_frame", 32'(burstIdx < NBURST), 1);
      chk("req_room", 32'(fifoQ.size() <= DEPTH - 4), 1);
      chk("req_en", 32'(cEn), 1);
    end
    if (oPix_Valid) popLog.push_back(oPix_Data);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseFs();
    iFrame_Start = 1'b1;
    tick();
    iFrame_Start = 1'b0;
  endtask

  task automatic waitReqs(input string name, input int n, input int budget);
    for (int i = 0; i < budget && reqLog.size() < n; i++) tick();
    chk(name, 32'(reqLog.size() >= n), 1);
  endtask

  task automatic checkSeq(input string name, input int n);
    int errs;
    errs = (popLog.size() == n) ? 0 : 1;
    for (int k = 0; k < popLog.size() && k < n; k++)
      if (popLog[k] !== 16'(k)) errs++;
    chk(name, 32'(errs), 0);
  endtask

  initial begin
    int n0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick();
    chk("rst_req", 32'(oRd_Req), 0);
    chk("rst_addr", 32'(oRd_Addr), 0);
    chk("rst_valid", 32'(oPix_Valid), 0);
    chk("rst_data", 32'(oPix_Data), 0);
    chk("rst_underflow", 32'(oUnderflow), 0);
    en = 1'b1;
    tick(10);
    chk("idle_no_req", 32'(reqLog.size()), 0);

    // First bursts and underflow on an empty FIFO
    lat = 6;
    pulseFs();
    iPix_Req = 1'b1;
    tick();
    iPix_Req = 1'b0;
    chk("uf_flag", 32'(oUnderflow), 1);
    chk("uf_valid", 32'(oPix_Valid), 0);
    chk("uf_data", 32'(oPix_Data), 0);
    waitReqs("first_reqs_timeout", 2, 100);
    if (reqLog.size() >= 2) begin
      chk("first_addr", 32'(reqLog[0]), 32'h000000);
      chk("second_addr", 32'(reqLog[1]), 32'h000004);
    end

    // Fill to 16 with no pops; requests resume only after 4 pops
    for (int i = 0; i < 600 && fifoQ.size() < DEPTH; i++) tick();
    chk("fifo_filled", 32'(fifoQ.size()), 16);
    tick(30);
    chk("no_req_when_full", 32'(oRd_Req), 0);
    chk("full_flag", 32'(dut.uFifo.full), 1);
    n0 = reqLog.size();
    iPix_Req = 1'b1;
    tick(3);
    iPix_Req = 1'b0;
    tick(20);
    chk("no_req_after_3_pops", 32'(reqLog.size()), 32'(n0));
    iPix_Req = 1'b1;
    tick();
    iPix_Req = 1'b0;
    waitReqs("req_after_4th_pop", n0 + 1, 30);
    if (popLog.size() >= 4) begin
      chk("pop0", 32'(popLog[0]), 0);
      chk("pop3", 32'(popLog[3]), 3);
    end

    // Run the frame to completion with random pixel pacing
    for (int i = 0; i < 8000 && !(burstIdx == NBURST && fifoQ.size() == 0 && pendQ.size() == 0); i++) begin
      iPix_Req = ($urandom % 4) != 0;
      tick();
    end
    iPix_Req = 1'b0;
    chk("frame_done", 32'(burstIdx), 32'(NBURST));
    if (reqLog.size() >= NBURST) begin
      chk("line1_addr", 32'(reqLog[H_T / 4]), 32'h000200);
      chk("last_addr", 32'(reqLog[NBURST - 1]), 32'h000A1C);
    end
    for (int i = 0; i < 50; i++) begin
      iPix_Req = $urandom % 2;
      tick();
    end
    iPix_Req = 1'b0;
    chk("no_req_after_fdone", 32'(reqLog.size()), 48);
    chk("underflow_sticky", 32'(oUnderflow), 1);
    checkSeq("frame_pop_sequence", NPIX);

    // Frame start while a burst is outstanding
    pulseFs();
    chk("underflow_cleared", 32'(oUnderflow), 0);
    n0 = reqLog.size();
    waitReqs("restart_reqs", n0 + 2, 200);
    tick(2);
    if (reqLog.size() >= n0 + 2) chk("drop_target_addr", 32'(reqLog[n0 + 1]), 32'h000004);
    popLog.delete();
    pulseFs();
    chk("req_held_drain", 32'(oRd_Req), 1);
    waitReqs("req_after_drain", n0 + 3, 100);
    if (reqLog.size() >= n0 + 3) chk("restart_addr", 32'(reqLog[n0 + 2]), 32'h000000);
    for (int i = 0; i < 200 && fifoQ.size() < 8; i++) tick();
    iPix_Req = 1'b1;
    tick(8);
    iPix_Req = 1'b0;
    tick(2);
    checkSeq("post_drain_sequence", 8);

    // Reset in the middle of a request
    for (int i = 0; i < 200 && !oRd_Req; i++) tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_req", 32'(oRd_Req), 0);
    chk("midrst_addr", 32'(oRd_Addr), 0);
    chk("midrst_count", 32'(dut.uFifo.count), 0);
    tick(10);
    chk("midrst_idle", 32'(oRd_Req), 0);

    // Randomized run: enable, pacing, latency and frame starts all random
    pulseFs();
    for (int i = 0; i < 4000; i++) begin
      lat          = $urandom_range(1, 8);
      en           = ($urandom % 8) != 0;
      iPix_Req     = ($urandom % 3) != 0;
      iFrame_Start = ($urandom % 300) == 0;
      tick();
    end
    iFrame_Start = 1'b0;
    iPix_Req     = 1'b0;
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
